fifo_uart_tx: RTL

Read-side consumer for the team's synchronous FIFO. It pops bytes through the FIFO's read port and serialises each one onto an 8N1-style UART line (start bit, LSB-first data, stop bit(s)). It sits between a FIFO filled by a producer and an off-chip TX pin, draining the FIFO whenever enabled and data is present.

---
 rtl/fifo_uart_tx_pkg.sv | 18 +
 rtl/fifo_uart_tx_baud_tick.sv | 32 +++
 rtl/fifo_uart_tx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_tx_pkg;

  // Transmitter sequencing: pop a word, wait for the registered FIFO data,
  // then shift out start, data and stop bits.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } tx_state_e;

  // Level of the serial line when no frame is in progress (mark state).
  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last cycle of each
// serial bit. A synchronous clear holds the count at zero so that the first
// bit of a frame always gets a full period.
module fifo_uart_tx_baud_tick #(
  parameter int BAUD_DIV = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] count;

  // Period counter: restarts on clear or after its terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Tick marks the final cycle of a bit period; suppressed while cleared.
  assign tick = !clr && (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer that serialises each popped word onto a UART line
// (start bit, LSB-first data, STOP_BITS stop bits). All outputs are registered.
// Read handshake: fifo_read is a single-cycle strobe issued only from IDLE
// while fifo_empty is low; the FIFO presents the word on fifo_data in the
// following cycle (LOAD), where it is captured.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 868,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  byte_done
);

  localparam int IW = $clog2(DATA_WIDTH) + 1;
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  tx_state_e             state, state_d;
  logic                  tx_d, fifo_read_d, busy_d, byte_done_d;
  logic [DATA_WIDTH-1:0] shift, shift_d;
  logic [IW-1:0]         bit_idx, bit_idx_d;
  logic                  timer_clr;
  logic                  tick;

  // The bit timer only runs while a frame is on the line.
  assign timer_clr = (state == IDLE) || (state == POP) || (state == LOAD);

  fifo_uart_tx_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (timer_clr),
    .tick (tick)
  );

  // State and registered outputs; reset forces the line to mark immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx        <= TX_IDLE_LEVEL;
      fifo_read <= 1'b0;
      busy      <= 1'b0;
      byte_done <= 1'b0;
      shift     <= '0;
      bit_idx   <= '0;
    end else begin
      state     <= state_d;
      tx        <= tx_d;
      fifo_read <= fifo_read_d;
      busy      <= busy_d;
      byte_done <= byte_done_d;
      shift     <= shift_d;
      bit_idx   <= bit_idx_d;
    end
  end

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d     = state;
    tx_d        = tx;
    fifo_read_d = 1'b0;
    busy_d      = busy;
    byte_done_d = 1'b0;
    shift_d     = shift;
    bit_idx_d   = bit_idx;
    case (state)
      IDLE: begin
        tx_d   = TX_IDLE_LEVEL;
        busy_d = 1'b0;
        if (enable && !fifo_empty) begin
          fifo_read_d = 1'b1;
          state_d     = POP;
        end
      end
      POP: begin
        busy_d  = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = fifo_data;
        tx_d    = ~TX_IDLE_LEVEL;
        state_d = START;
      end
      START: begin
        if (tick) begin
          tx_d      = shift[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == LAST_BIT) begin
            tx_d      = TX_IDLE_LEVEL;
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            shift_d   = shift >> 1;
            tx_d      = shift[1];
            bit_idx_d = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_idx == LAST_STOP) begin
            byte_done_d = 1'b1;
            busy_d      = 1'b0;
            bit_idx_d   = '0;
            state_d     = IDLE;
          end else begin
            bit_idx_d = bit_idx + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
